// File: rtl/i2c_reg_sequencer_if.sv
// i2c_reg_sequencer_if: request, byte-engine command/response and completion signals of the sequencer
interface i2c_reg_sequencer_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_rw;
  logic [6:0] req_dev;
  logic [7:0] req_reg;
  logic [7:0] req_wdata;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [7:0] cmd_data;
  logic       cmd_nack;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       rsp_nack;
  logic       done;
  logic [7:0] rdata;
  logic [1:0] err;
  logic       busy;
  modport slave (
    input  req_valid, req_rw, req_dev, req_reg, req_wdata, cmd_ready, rsp_valid, rsp_data, rsp_nack,
    output req_ready, cmd_valid, cmd_op, cmd_data, cmd_nack, done, rdata, err, busy
  );
  modport master (
    output req_valid, req_rw, req_dev, req_reg, req_wdata, cmd_ready, rsp_valid, rsp_data, rsp_nack,
    input  req_ready, cmd_valid, cmd_op, cmd_data, cmd_nack, done, rdata, err, busy
  );
endinterface

// File: rtl/i2c_reg_sequencer.sv
// i2c_reg_sequencer: expands one register read/write request into I2C byte-engine commands
module i2c_reg_sequencer #(
  parameter int TIMEOUT_CYCLES = 20000
) (
  input logic                clk,
  input logic                rst,
  i2c_reg_sequencer_if.slave bus
);
  localparam int CW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [2:0] OP_START = 3'd0, OP_WRITE = 3'd1, OP_READ = 3'd2, OP_STOP = 3'd3, OP_RESTART = 3'd4;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  state_t          state, state_n;
  logic            rw;
  logic [6:0]      dev;
  logic [7:0]      reg_q, wdata, rdata, data;
  logic [1:0]      err;
  logic [2:0]      step, stop_step, op;
  logic [CW-1:0]   cnt;
  logic            tmo, issue;
  // Step index walks the write list (0..4) or the read list (0..6); the last step is always STOP
  assign stop_step = rw ? 3'd6 : 3'd4;
  assign op = step == 3'd0 ? OP_START
            : step == stop_step ? OP_STOP
            : rw && step == 3'd3 ? OP_RESTART
            : rw && step == 3'd5 ? OP_READ
            : OP_WRITE;
  assign data = op != OP_WRITE ? 8'h00
              : step == 3'd1 ? {dev, 1'b0}
              : step == 3'd2 ? reg_q
              : rw ? {dev, 1'b1}
              : wdata;
  assign tmo = TIMEOUT_CYCLES != 0 && cnt == CW'(TIMEOUT_CYCLES - 1);
  assign issue = state == ISSUE;
  assign bus.req_ready = state == IDLE;
  assign bus.cmd_valid = issue;
  assign bus.cmd_op    = issue ? op : OP_START;
  assign bus.cmd_data  = issue ? data : 8'h00;
  assign bus.cmd_nack  = issue && op == OP_READ;
  assign bus.done      = state == DONE;
  assign bus.rdata     = rdata;
  assign bus.err       = err;
  assign bus.busy      = state != IDLE;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = bus.req_valid ? ISSUE : IDLE;
      ISSUE:   state_n = bus.cmd_ready ? WAIT : ISSUE;
      WAIT:    state_n = bus.rsp_valid ? (op == OP_STOP ? DONE : ISSUE) : tmo ? DONE : WAIT;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rw    <= 1'b0;
      dev   <= '0;
      reg_q <= '0;
      wdata <= '0;
      step  <= '0;
      cnt   <= '0;
      rdata <= '0;
      err   <= '0;
    end else begin
      if (state == IDLE && bus.req_valid) begin
        rw    <= bus.req_rw;
        dev   <= bus.req_dev;
        reg_q <= bus.req_reg;
        wdata <= bus.req_wdata;
        step  <= '0;
        err   <= '0;
      end
      if (issue && bus.cmd_ready) cnt <= '0;
      if (state == WAIT) begin
        cnt <= cnt == '1 ? cnt : cnt + 1'b1;
        // A NACKed byte skips straight to STOP; err stays set through the STOP response
        if (bus.rsp_valid) begin
          if (op == OP_READ) rdata <= bus.rsp_data;
          if (op == OP_WRITE && bus.rsp_nack) begin
            err  <= 2'd1;
            step <= stop_step;
          end else if (op != OP_STOP) step <= step + 3'd1;
        end else if (tmo) err <= 2'd2;
      end
    end
  end
endmodule

// File: tb/tb_i2c_reg_sequencer.sv
// tb_i2c_reg_sequencer: directed scoreboard bench with a behavioural byte engine and a completion monitor
module tb_i2c_reg_sequencer;
  localparam logic [2:0] S = 3'd0, W = 3'd1, R = 3'd2, P = 3'd3, RS = 3'd4;
  localparam int STALL = 10;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  i2c_reg_sequencer_if bus();
  i2c_reg_sequencer #(.TIMEOUT_CYCLES(16)) dut (.clk(clk), .rst(rst), .bus(bus));
  int vectors = 0, miscompares = 0;
  int cyc = 0, hs_n = 0, hs_cyc = 0, stall_at = -1, stall_left = 0;
  bit nack_addr = 0, hung = 0, pend = 0, pend_nack = 0, tmo_test = 0;
  logic [7:0] pend_data = 8'h00, read_byte = 8'h00, st_data;
  logic [2:0] st_op;
  logic [10:0] exp_cmd[$];
  logic [9:0]  exp_done[$];
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic void c(input logic [2:0] op, input logic [7:0] d);
    exp_cmd.push_back({op, d});
  endfunction
  // Byte engine: accepts commands, answers one cycle after the handshake, logs every command
  initial begin
    bus.cmd_ready = 1'b1;
    bus.rsp_valid = 1'b0;
    bus.rsp_data  = 8'h00;
    bus.rsp_nack  = 1'b0;
    forever begin
      @(negedge clk);
      bus.rsp_valid = pend;
      bus.rsp_data  = pend ? pend_data : 8'h00;
      bus.rsp_nack  = pend && pend_nack;
      pend = 0;
      if (bus.cmd_valid && hs_n == stall_at && stall_left > 0) begin
        if (stall_left == STALL) {st_op, st_data} = {bus.cmd_op, bus.cmd_data};
        else begin
          check("stall_op", bus.cmd_op, st_op);
          check("stall_data", bus.cmd_data, st_data);
        end
        stall_left--;
        bus.cmd_ready = 1'b0;
      end else begin
        bus.cmd_ready = 1'b1;
        if (bus.cmd_valid) begin
          hs_n++;
          hs_cyc = cyc + 1;
          if (exp_cmd.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL cmd_extra: got op %0d data %0h expected none", bus.cmd_op, bus.cmd_data);
          end else check("cmd", {bus.cmd_op, bus.cmd_data}, exp_cmd.pop_front());
          check("cmd_nack", bus.cmd_nack, bus.cmd_op == R);
          pend      = !hung;
          pend_nack = nack_addr && bus.cmd_op == W;
          pend_data = bus.cmd_op == R ? read_byte : 8'h00;
        end
      end
    end
  end
  // Completion monitor
  initial forever begin
    @(negedge clk);
    if (bus.done) begin
      if (exp_done.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL done_extra: got err %0d rdata %0h expected no completion", bus.err, bus.rdata);
      end else begin
        logic [9:0] e;
        e = exp_done.pop_front();
        check("done_err", bus.err, e[9:8]);
        check("done_rdata", bus.rdata, e[7:0]);
      end
      if (tmo_test) check("timeout_latency", cyc - hs_cyc, 16);
    end
  end
  task automatic send(input bit rw, input logic [6:0] d, input logic [7:0] r, input logic [7:0] w);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_rw    = rw;
    bus.req_dev   = d;
    bus.req_reg   = r;
    bus.req_wdata = w;
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask
  task automatic wait_done(input string name);
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (bus.done) break;
    end
    if (!bus.done) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_timeout: got no done expected done within 300 cycles", name);
    end else begin
      @(negedge clk);
      check({name, "_pulse"}, bus.done, 0);
      check({name, "_drained"}, exp_cmd.size(), 0);
    end
  endtask
  task automatic check_reset_outputs(input string name);
    check({name, "_req_ready"}, bus.req_ready, 1);
    check({name, "_cmd_valid"}, bus.cmd_valid, 0);
    check({name, "_cmd_op"}, bus.cmd_op, 0);
    check({name, "_cmd_data"}, bus.cmd_data, 0);
    check({name, "_cmd_nack"}, bus.cmd_nack, 0);
    check({name, "_done"}, bus.done, 0);
    check({name, "_rdata"}, bus.rdata, 0);
    check({name, "_err"}, bus.err, 0);
    check({name, "_busy"}, bus.busy, 0);
  endtask
  initial begin
    int h0;
    bus.req_valid = 1'b0;
    bus.req_rw    = 1'b0;
    bus.req_dev   = '0;
    bus.req_reg   = '0;
    bus.req_wdata = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    rst = 1'b0;
    c(S, 8'h00); c(W, 8'hA0); c(W, 8'h10); c(W, 8'hA5); c(P, 8'h00);
    exp_done.push_back({2'd0, 8'h00});
    send(0, 7'h50, 8'h10, 8'hA5);
    wait_done("write");
    read_byte = 8'h3C;
    c(S, 8'h00); c(W, 8'hA0); c(W, 8'h22); c(RS, 8'h00); c(W, 8'hA1); c(R, 8'h00); c(P, 8'h00);
    exp_done.push_back({2'd0, 8'h3C});
    send(1, 7'h50, 8'h22, 8'hFF);
    wait_done("read");
    nack_addr = 1;
    c(S, 8'h00); c(W, 8'h54); c(P, 8'h00);
    exp_done.push_back({2'd1, 8'h3C});
    send(0, 7'h2A, 8'h33, 8'h77);
    wait_done("nack");
    nack_addr = 0;
    stall_at = hs_n + 2;
    stall_left = STALL;
    c(S, 8'h00); c(W, 8'h3E); c(W, 8'h05); c(W, 8'h9E); c(P, 8'h00);
    exp_done.push_back({2'd0, 8'h3C});
    send(0, 7'h1F, 8'h05, 8'h9E);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("busy_req_ready", bus.req_ready, 0);
      bus.req_valid = 1'b1;
      bus.req_dev   = 7'h7F;
    end
    bus.req_valid = 1'b0;
    wait_done("stall");
    hung = 1;
    tmo_test = 1;
    c(S, 8'h00);
    exp_done.push_back({2'd2, 8'h3C});
    send(0, 7'h50, 8'h10, 8'hA5);
    wait_done("timeout");
    tmo_test = 0;
    hung = 0;
    read_byte = 8'hC3;
    h0 = hs_n;
    c(S, 8'h00); c(W, 8'hA0); c(W, 8'h22); c(RS, 8'h00); c(W, 8'hA1); c(R, 8'h00); c(P, 8'h00);
    send(1, 7'h50, 8'h22, 8'h00);
    for (int k = 0; k < 100; k++) begin
      @(posedge clk);
      if (hs_n == h0 + 4) break;
    end
    #1;
    check("abort_busy", bus.busy, 1);
    #1;
    rst = 1'b1;
    #1;
    check_reset_outputs("abort");
    exp_cmd.delete();
    exp_done.delete();
    pend = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    c(S, 8'h00); c(W, 8'hA0); c(W, 8'h44); c(W, 8'h5A); c(P, 8'h00);
    exp_done.push_back({2'd0, 8'h00});
    send(0, 7'h50, 8'h44, 8'h5A);
    wait_done("after_rst");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
